reloj_hora_bcd: RTL and testbench

//  Time-of-day counter HH:MM:SS.CC kept directly in packed BCD; drives the 8-digit display stage (hora_display input).

---
 rtl/reloj_pkg.sv | 25 ++
 rtl/contador_bcd_par.sv | 47 ++++
 rtl/reloj_hora_bcd.sv | 91 +++++++++
 tb/tb_reloj_hora_bcd.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reloj_pkg.sv
// Shared types, field limits and the load validity check for the BCD time-of-day clock.
package reloj_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] MAX_HH = 8'h23;
    localparam logic [7:0] MAX_MS = 8'h59;
    localparam logic [7:0] MAX_CC = 8'h99;

    // Every nibble must be a decimal digit before the field limits mean anything.
    function automatic logic bcd_valid_time(input logic [31:0] v);
        logic ok;
        bcd_t nib;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nib = v[i*4 +: 4];
            if (nib > bcd_t'(9)) ok = 1'b0;
        end
        if (v[31:24] > MAX_HH) ok = 1'b0;
        if (v[23:16] > MAX_MS) ok = 1'b0;
        if (v[15:8]  > MAX_MS) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/contador_bcd_par.sv
// Two-digit packed-BCD counter wrapping at MOD_MAX; clear beats load beats increment.
module contador_bcd_par
    import reloj_pkg::*;
#(
    parameter logic [7:0] MOD_MAX = MAX_CC
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_inc_en,
    output logic [7:0] o_q,
    output logic       o_carry
);

    logic [7:0] r_q;
    logic [7:0] w_q_inc;
    bcd_t       w_lo;
    bcd_t       w_hi;

    assign w_lo = r_q[3:0];
    assign w_hi = r_q[7:4];

    always_comb begin
        w_q_inc = {w_hi, w_lo + 4'd1};
        if (r_q == MOD_MAX)
            w_q_inc = 8'h00;
        else if (w_lo == 4'd9)
            w_q_inc = {w_hi + 4'd1, 4'd0};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= 8'h00;
        else if (i_clr)
            r_q <= 8'h00;
        else if (i_load)
            r_q <= i_load_val;
        else if (i_inc_en)
            r_q <= w_q_inc;
    end

    assign o_q     = r_q;
    assign o_carry = i_inc_en && (r_q == MOD_MAX);

endmodule

// File: rtl/reloj_hora_bcd.sv
// HH:MM:SS.CC clock in packed BCD: prescaler, command priority and a four-stage carry chain.
module reloj_hora_bcd
    import reloj_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic        clk,
    input  logic        CPU_RESETN,
    input  logic        run,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc_hh,
    input  logic        inc_mm,
    output logic [31:0] hora_display,
    output logic        tick_seg,
    output logic        load_err
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_presc;
    logic          r_tick_seg;
    logic          r_load_err;

    logic w_load_ok, w_ld, w_set, w_set_mm, w_set_hh, w_tick, w_tick_apply, w_sub_clr;
    logic w_cc_carry, w_ss_carry, w_mm_carry, w_unused_day_wrap;
    logic [7:0] w_cc, w_ss, w_mm, w_hh;

    // Only one command class acts per cycle: clr, then load, then set pulses, then the tick.
    assign w_load_ok    = load && bcd_valid_time(load_val);
    assign w_ld         = !clr && w_load_ok;
    assign w_set        = !clr && !load && (inc_hh || inc_mm);
    assign w_set_mm     = w_set && inc_mm;
    assign w_set_hh     = w_set && inc_hh;
    assign w_tick       = run && (r_presc == PRESC_LAST);
    assign w_tick_apply = w_tick && !clr && !load && !inc_hh && !inc_mm;
    assign w_sub_clr    = clr || w_set_mm;

    contador_bcd_par #(.MOD_MAX(MAX_CC)) u_cc (
        .i_clk(clk), .i_rst_n(CPU_RESETN), .i_clr(w_sub_clr), .i_load(w_ld),
        .i_load_val(load_val[7:0]), .i_inc_en(w_tick_apply), .o_q(w_cc), .o_carry(w_cc_carry)
    );

    contador_bcd_par #(.MOD_MAX(MAX_MS)) u_ss (
        .i_clk(clk), .i_rst_n(CPU_RESETN), .i_clr(w_sub_clr), .i_load(w_ld),
        .i_load_val(load_val[15:8]), .i_inc_en(w_cc_carry), .o_q(w_ss), .o_carry(w_ss_carry)
    );

    contador_bcd_par #(.MOD_MAX(MAX_MS)) u_mm (
        .i_clk(clk), .i_rst_n(CPU_RESETN), .i_clr(clr), .i_load(w_ld),
        .i_load_val(load_val[23:16]), .i_inc_en(w_ss_carry || w_set_mm), .o_q(w_mm),
        .o_carry(w_mm_carry)
    );

    // A minute set at 59 must not ripple into the hours, so only the tick chain carries.
    contador_bcd_par #(.MOD_MAX(MAX_HH)) u_hh (
        .i_clk(clk), .i_rst_n(CPU_RESETN), .i_clr(clr), .i_load(w_ld),
        .i_load_val(load_val[31:24]), .i_inc_en((w_mm_carry && w_tick_apply) || w_set_hh),
        .o_q(w_hh), .o_carry(w_unused_day_wrap)
    );

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            r_presc <= '0;
        else if (clr || w_load_ok || w_set_mm)
            r_presc <= '0;
        else if (load)
            r_presc <= r_presc;
        else if (run)
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_tick_seg <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tick_seg <= w_cc_carry;
            r_load_err <= !clr && load && !w_load_ok;
        end
    end

    assign hora_display = {w_hh, w_mm, w_ss, w_cc};
    assign tick_seg     = r_tick_seg;
    assign load_err     = r_load_err;

endmodule

// File: tb/tb_reloj_hora_bcd.sv
// Bench for reloj_hora_bcd with a 10-cycle tick; reference keeps time as total centiseconds.
module tb_reloj_hora_bcd;

    localparam int DIV    = 10;
    localparam int DAY_CS = 24 * 60 * 60 * 100;

    logic        clk;
    logic        CPU_RESETN;
    logic        run;
    logic        clr;
    logic        load;
    logic [31:0] load_val;
    logic        inc_hh;
    logic        inc_mm;
    logic [31:0] hora_display;
    logic        tick_seg;
    logic        load_err;

    int checks;
    int errors;

    int m_total;
    int m_presc;
    bit m_tick_seg;
    bit m_load_err;

    reloj_hora_bcd #(.CLK_FREQ(10), .TICK_HZ(1)) dut (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .run(run), .clr(clr), .load(load),
        .load_val(load_val), .inc_hh(inc_hh), .inc_mm(inc_mm),
        .hora_display(hora_display), .tick_seg(tick_seg), .load_err(load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] two(input int x);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(x / 10);
        u = 4'(x % 10);
        return {t, u};
    endfunction

    function automatic logic [31:0] cs_to_bcd(input int t);
        return {two(t / 360000), two((t / 6000) % 60), two((t / 100) % 60), two(t % 100)};
    endfunction

    function automatic int dig(input logic [31:0] v, input int i);
        return int'(v[i*4 +: 4]);
    endfunction

    function automatic bit load_ok(input logic [31:0] v);
        for (int i = 0; i < 8; i++)
            if (dig(v, i) > 9) return 1'b0;
        return (dig(v, 7) * 10 + dig(v, 6) < 24) && (dig(v, 5) * 10 + dig(v, 4) < 60) &&
               (dig(v, 3) * 10 + dig(v, 2) < 60);
    endfunction

    function automatic int bcd_to_cs(input logic [31:0] v);
        int h, m, s, c;
        h = dig(v, 7) * 10 + dig(v, 6);
        m = dig(v, 5) * 10 + dig(v, 4);
        s = dig(v, 3) * 10 + dig(v, 2);
        c = dig(v, 1) * 10 + dig(v, 0);
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    task automatic model_step();
        int h, m, s, c;
        m_tick_seg = 1'b0;
        m_load_err = 1'b0;
        if (clr) begin
            m_total = 0;
            m_presc = 0;
        end else if (load) begin
            if (load_ok(load_val)) begin
                m_total = bcd_to_cs(load_val);
                m_presc = 0;
            end else begin
                m_load_err = 1'b1;
            end
        end else if (inc_hh || inc_mm) begin
            h = m_total / 360000;
            m = (m_total / 6000) % 60;
            s = (m_total / 100) % 60;
            c = m_total % 100;
            if (inc_hh) h = (h + 1) % 24;
            if (inc_mm) begin
                m = (m + 1) % 60;
                s = 0;
                c = 0;
                m_presc = 0;
            end else if (run) begin
                m_presc = (m_presc + 1) % DIV;
            end
            m_total = ((h * 60 + m) * 60 + s) * 100 + c;
        end else if (run) begin
            if (m_presc == DIV - 1) begin
                m_presc    = 0;
                m_tick_seg = (m_total % 100) == 99;
                m_total    = (m_total + 1) % DAY_CS;
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("hora_display", hora_display, cs_to_bcd(m_total));
        chk("tick_seg", {31'd0, tick_seg}, {31'd0, m_tick_seg});
        chk("load_err", {31'd0, load_err}, {31'd0, m_load_err});
        clr    = 1'b0;
        load   = 1'b0;
        inc_hh = 1'b0;
        inc_mm = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] v);
        load_val = v;
        load     = 1'b1;
        cyc();
    endtask

    initial begin
        logic [31:0] held;
        int r;
        checks     = 0;
        errors     = 0;
        m_total    = 0;
        m_presc    = 0;
        CPU_RESETN = 1'b0;
        run        = 1'b0;
        clr        = 1'b0;
        load       = 1'b0;
        load_val   = 32'h0;
        inc_hh     = 1'b0;
        inc_mm     = 1'b0;

        // reset values
        #12;
        chk("rst_hora", hora_display, 32'h0);
        chk("rst_tick", {31'd0, tick_seg}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        @(posedge clk);
        #1;
        CPU_RESETN = 1'b1;

        // free run, then asynchronous reset mid-count
        run = 1'b1;
        repeat (23) cyc();
        #3;
        CPU_RESETN = 1'b0;
        #1;
        m_total = 0;
        m_presc = 0;
        chk("async_rst_hora", hora_display, 32'h0);
        chk("async_rst_tick", {31'd0, tick_seg}, 32'd0);
        chk("async_rst_err", {31'd0, load_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held_hora", hora_display, 32'h0);
        CPU_RESETN = 1'b1;

        // full day rollover
        do_load(32'h2359_5999);
        chk("load_value", hora_display, 32'h2359_5999);
        repeat (9) cyc();
        chk("pre_rollover", hora_display, 32'h2359_5999);
        cyc();
        chk("rollover", hora_display, 32'h0000_0000);
        chk("rollover_tick", {31'd0, tick_seg}, 32'd1);
        cyc();
        chk("tick_one_cycle", {31'd0, tick_seg}, 32'd0);

        // hour carry and centisecond carry
        do_load(32'h1259_5999);
        repeat (10) cyc();
        chk("hour_carry", hora_display, 32'h1300_0000);
        do_load(32'h0000_0099);
        repeat (10) cyc();
        chk("cc_carry", hora_display, 32'h0000_0100);
        chk("cc_carry_tick", {31'd0, tick_seg}, 32'd1);

        // rejected loads
        run  = 1'b0;
        held = cs_to_bcd(m_total);
        do_load(32'h2460_0000);
        chk("bad_load_err", {31'd0, load_err}, 32'd1);
        chk("bad_load_hold", hora_display, held);
        cyc();
        chk("bad_load_err_clear", {31'd0, load_err}, 32'd0);
        do_load(32'h000A_0000);
        chk("bad_nibble_err", {31'd0, load_err}, 32'd1);
        chk("bad_nibble_hold", hora_display, held);
        cyc();
        run = 1'b1;

        // minute and hour set pulses
        do_load(32'h0959_3012);
        inc_mm = 1'b1;
        cyc();
        chk("inc_mm_wrap", hora_display, 32'h0900_0000);
        do_load(32'h2310_0000);
        inc_hh = 1'b1;
        cyc();
        chk("inc_hh_wrap", hora_display, 32'h0010_0000);
        do_load(32'h0500_0000);
        repeat (9) cyc();
        inc_hh = 1'b1;
        cyc();
        chk("tick_lost", hora_display, 32'h0600_0000);
        repeat (10) cyc();
        chk("tick_after_lost", hora_display, 32'h0600_0001);

        // pause keeps prescaler phase
        do_load(32'h0100_0000);
        repeat (4) cyc();
        run = 1'b0;
        repeat (50) cyc();
        chk("paused", hora_display, 32'h0100_0000);
        run = 1'b1;
        repeat (5) cyc();
        chk("resume_wait", hora_display, 32'h0100_0000);
        cyc();
        chk("resume_tick", hora_display, 32'h0100_0001);

        // clr wins over load
        clr = 1'b1;
        do_load(32'h1234_5678);
        chk("clr_over_load", hora_display, 32'h0);

        // randomized mix against the reference
        repeat (500) begin
            run = ($urandom_range(0, 9) != 0);
            r   = $urandom_range(0, 99);
            if (r < 3) begin
                clr = 1'b1;
            end else if (r < 8) begin
                load_val = cs_to_bcd($urandom_range(0, DAY_CS - 1));
                load     = 1'b1;
            end else if (r < 11) begin
                load_val = $urandom;
                load     = 1'b1;
            end else if (r < 15) begin
                inc_hh = 1'b1;
            end else if (r < 19) begin
                inc_mm = 1'b1;
            end else if (r < 21) begin
                inc_hh = 1'b1;
                inc_mm = 1'b1;
            end else if (r < 22) begin
                load_val = cs_to_bcd($urandom_range(0, DAY_CS - 1));
                load     = 1'b1;
                inc_mm   = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
